hex_display_scanner: RTL and testbench
======================================

Name: hex_display_scanner

Overview:
- Time-multiplexed controller for a bank of common-anode 7-segment digits that share one segment bus.
- Holds a double-buffered hex value and scans one digit at a time, with a blanking dead-time between digits to prevent ghosting.
- Decodes each nibble to active-low segments internally.
- Producers load new values through a valid/ready handshake; a new value is committed only at a frame boundary, so the display never tears.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (legal 1..8).
- PRESCALE, 50000, clk cycles each digit is lit (>=2).
- DEAD_CYCLES, 500, clk cycles all digits are dark between digits (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  scan enable; 0 = display dark.
- load_valid  input  1  producer has a value on load_data.
- load_data  input  4*NUM_DIGITS  hex value; nibble k drives digit k (nibble 0 = least significant = an_n[0]).
- dp_in  input  NUM_DIGITS  decimal point per digit, 1 = lit; sampled live, not buffered.
- load_ready  output  1  pending buffer is empty; a load is accepted this cycle.
- seg_n  output  7  active-low segments; bit0=a(top), 1=b, 2=c, 3=d, 4=e, 5=f, 6=g(middle).
- dp_n  output  1  active-low decimal point.
- an_n  output  NUM_DIGITS  active-low digit enables; at most one low at any time.
- frame_done  output  1  one-cycle pulse when the last digit finishes.

Behaviour:
- Reset (async): seg_n=7'h7F, dp_n=1, an_n=all 1, load_ready=1, frame_done=0.
  - Active and pending buffers cleared; pending marked empty.
  - State DEAD, counter 0, digit index 0.
- State machine:
  - DEAD: all anodes off. After DEAD_CYCLES cycles go to SHOW.
  - SHOW: digit idx lit. After PRESCALE cycles go to DEAD.
  - On the SHOW->DEAD transition: if idx = NUM_DIGITS-1, idx wraps to 0 and frame_done pulses on that cycle; otherwise idx+1.
- Output timing: all outputs registered; pins reflect the state/idx of the previous cycle (1-cycle latency).
  - One frame = NUM_DIGITS*(PRESCALE+DEAD_CYCLES) cycles.
- Decode (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Load handshake:
  - Transfer when load_valid && load_ready; load_data is captured into pending and load_ready drops the next cycle.
  - load_valid without load_ready is ignored; the producer holds its data.
- Commit:
  - On the frame_done cycle, if pending is full, pending moves to active and load_ready returns to 1 the following cycle.
  - A transfer in the same cycle as frame_done lands in pending and commits at the next frame boundary.
- en=0:
  - Counter and idx held at DEAD/0; all outputs dark; frame_done=0.
  - Loads are still accepted; pending commits to active on the cycle after capture.
  - en rising starts a fresh DEAD period at idx 0.
- en falling mid-SHOW: outputs go dark on the next cycle and the scan restarts from idx 0.
- rst mid-operation: immediate dark outputs; any pending load is discarded.
- dp_n = ~dp_in[idx] during SHOW; 1 otherwise.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: during SHOW, any digit above the most significant nonzero active nibble is dark (an_n stays all 1, seg_n=7'h7F, dp_n=1). Scan timing is unchanged. Digit 0 is always shown, so value 0 displays as a single "0".
- Undefined: every digit is always displayed, including leading zeros.

Test Plan (NUM_DIGITS=4, PRESCALE=4, DEAD_CYCLES=2):
- Assert rst mid-SHOW -> same-cycle seg_n=7F, an_n=1111, load_ready=1. After release: 2 dark cycles, then an_n=1110 and seg_n=1000000 for 4 cycles.
- Load 16'h12AF with en=1 -> load_ready=0 until frame_done. Next frame shows digit0=0001110 (F), digit1=0001000 (A), digit2=0100100, digit3=1111001. frame_done pulses every 24 cycles.
- Load 16'h0001 and hold load_valid in the frame_done cycle with pending empty -> value shown from the frame after next; the second load_valid is ignored until load_ready=1.
- en=0 with load 16'hBEEF -> outputs dark, commit on the next cycle. en=1 -> first lit digit is an_n=1110, seg_n=0001110.
- dp_in=4'b0100 -> dp_n=0 only while an_n=1011.
- LEADING_ZERO_BLANK_EN defined, load 16'h0030 -> digits 2 and 3 dark, digit1=0110000, digit0=1000000. Load 16'h0000 -> only digit0 lit with 1000000.

Source files
------------

// File: rtl/hex_display_scanner.sv
// Time-multiplexed 7-segment scanner: double-buffered hex value, dead-time blanking, active-low outputs.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero nibble.
module hex_display_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int PRESCALE    = 50000,
  parameter int DEAD_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    load_ready,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int CNT_MAX = (PRESCALE > DEAD_CYCLES) ? PRESCALE : DEAD_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);
  localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] SHOW_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  localparam logic ST_DEAD = 1'b0;
  localparam logic ST_SHOW = 1'b1;

  logic                       state;
  logic [CW-1:0]              cnt;
  logic [IW-1:0]              idx;
  logic [NUM_DIGITS-1:0][3:0] active;
  logic [NUM_DIGITS-1:0][3:0] pending;
  logic                       pend_full;

  logic       lit_next;
  logic       fd_next;
  logic [3:0] nib;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_to_seg = 7'b1000000;
      4'h1: hex_to_seg = 7'b1111001;
      4'h2: hex_to_seg = 7'b0100100;
      4'h3: hex_to_seg = 7'b0110000;
      4'h4: hex_to_seg = 7'b0011001;
      4'h5: hex_to_seg = 7'b0010010;
      4'h6: hex_to_seg = 7'b0000010;
      4'h7: hex_to_seg = 7'b1111000;
      4'h8: hex_to_seg = 7'b0000000;
      4'h9: hex_to_seg = 7'b0010000;
      4'hA: hex_to_seg = 7'b0001000;
      4'hB: hex_to_seg = 7'b0000011;
      4'hC: hex_to_seg = 7'b1000110;
      4'hD: hex_to_seg = 7'b0100001;
      4'hE: hex_to_seg = 7'b0000110;
      default: hex_to_seg = 7'b0001110;
    endcase
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  logic [IW-1:0] msd;

  // Digit 0 is always a candidate, so an all-zero value still shows one "0".
  always_comb begin
    msd = '0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (active[k] != 4'h0) msd = IW'(k);
    end
  end
`endif

  always_comb begin
    nib      = active[idx];
    lit_next = en && (state == ST_SHOW);
`ifdef LEADING_ZERO_BLANK_EN
    lit_next = lit_next && (idx <= msd);
`endif
    fd_next  = en && (state == ST_SHOW) && (cnt == SHOW_LAST) && (idx == IDX_LAST);
  end

  assign load_ready = ~pend_full;

  // Pins are registered from the previous cycle's scan position; en gates them so a
  // mid-SHOW disable goes dark on the very next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_DEAD;
      cnt        <= '0;
      idx        <= '0;
      active     <= '0;
      pending    <= '0;
      pend_full  <= 1'b0;
      seg_n      <= 7'h7F;
      dp_n       <= 1'b1;
      an_n       <= '1;
      frame_done <= 1'b0;
    end else begin
      seg_n      <= lit_next ? hex_to_seg(nib) : 7'h7F;
      an_n       <= lit_next ? ~(NUM_DIGITS'(1) << idx) : '1;
      dp_n       <= lit_next ? ~dp_in[idx] : 1'b1;
      frame_done <= fd_next;

      if (!en) begin
        state <= ST_DEAD;
        cnt   <= '0;
        idx   <= '0;
      end else if (state == ST_DEAD) begin
        if (cnt == DEAD_LAST) begin
          state <= ST_SHOW;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        if (cnt == SHOW_LAST) begin
          state <= ST_DEAD;
          cnt   <= '0;
          idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      // Capture and commit never coincide: capture needs pending empty, commit needs it full.
      if (load_valid && !pend_full) begin
        pending   <= load_data;
        pend_full <= 1'b1;
      end else if (pend_full && (frame_done || !en)) begin
        active    <= pending;
        pend_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Self-checking bench for hex_display_scanner: directed steps plus randomized traffic
// against a frame-position reference model (honours LEADING_ZERO_BLANK_EN).
module tb_hex_display_scanner;

  localparam int N     = 4;
  localparam int P     = 4;
  localparam int D     = 2;
  localparam int SLOT  = P + D;
  localparam int FRAME = N * SLOT;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load_valid;
  logic [15:0] load_data;
  logic [3:0]  dp_in;
  logic        load_ready;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [16];

  logic [15:0] m_active;
  logic [15:0] m_pend;
  bit          m_full;
  bit          m_fd;
  int          m_pos;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_an;

  hex_display_scanner #(.NUM_DIGITS(N), .PRESCALE(P), .DEAD_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .en(en), .load_valid(load_valid), .load_data(load_data),
    .dp_in(dp_in), .load_ready(load_ready), .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_seg"}, {9'b0, seg_n}, {9'b0, e_seg});
    checkOutput({tag, "_an"}, {12'b0, an_n}, {12'b0, e_an});
    checkOutput({tag, "_dp"}, {15'b0, dp_n}, {15'b0, e_dp});
    checkOutput({tag, "_fd"}, {15'b0, frame_done}, {15'b0, m_fd});
    checkOutput({tag, "_ready"}, {15'b0, load_ready}, {15'b0, !m_full});
  endtask

  task automatic modelReset();
    m_active = '0;
    m_pend   = '0;
    m_full   = 0;
    m_fd     = 0;
    m_pos    = 0;
    e_seg    = 7'h7F;
    e_dp     = 1'b1;
    e_an     = 4'hF;
  endtask

  task automatic applyStimulus(input logic e, input logic lv, input logic [15:0] d, input logic [3:0] dp);
    en         = e;
    load_valid = lv;
    load_data  = d;
    dp_in      = dp;
  endtask

  // One clock: the model advances from the inputs seen at the edge, then outputs are compared 1ns later.
  task automatic tick(input string tag);
    int         digit;
    int         msd;
    bit         lit;
    bit         new_fd;
    logic [3:0] nib;
    @(posedge clk);
    digit = m_pos / SLOT;
    lit   = en && ((m_pos % SLOT) >= D);
    msd   = 0;
`ifdef LEADING_ZERO_BLANK_EN
    for (int k = 1; k < N; k++) if (m_active[4*k +: 4] != 4'h0) msd = k;
    lit = lit && (digit <= msd);
`endif
    nib    = m_active[4*digit +: 4];
    e_seg  = lit ? seg_tab[nib] : 7'h7F;
    e_an   = lit ? ~(4'b0001 << digit) : 4'hF;
    e_dp   = lit ? ~dp_in[digit] : 1'b1;
    new_fd = en && (m_pos == FRAME - 1);
    if (load_valid && !m_full) begin
      m_pend = load_data;
      m_full = 1;
    end else if (m_full && (m_fd || !en)) begin
      m_active = m_pend;
      m_full   = 0;
    end
    m_fd  = new_fd;
    m_pos = en ? (m_pos + 1) % FRAME : 0;
    #1;
    checkAll(tag);
  endtask

  task automatic pulseReset(input string tag);
    #1 rst = 1'b1;
    modelReset();
    #1 checkAll(tag);
    #2 rst = 1'b0;
  endtask

  initial begin
    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001; seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
    seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010; seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000; seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
    seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001; seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h0, 4'h0);
    modelReset();
    #3 checkAll("reset");
    #1 rst = 1'b0;

    $display("[TB] scanning zeros after reset");
    applyStimulus(1'b1, 1'b0, 16'h0, 4'h0);
    repeat (30) tick("idle_zero");

    $display("[TB] reset mid-SHOW with a pending load");
    applyStimulus(1'b1, 1'b1, 16'h9999, 4'h0);
    tick("load_9999");
    applyStimulus(1'b1, 1'b0, 16'h0, 4'h0);
    for (int i = 0; i < 2 * SLOT && e_an == 4'hF; i++) tick("seek_show");
    checkOutput("seek_show", {15'b0, an_n != 4'hF}, 16'd1);
    pulseReset("rst_mid_show");
    repeat (30) tick("after_rst");

    $display("[TB] load 12AF");
    applyStimulus(1'b1, 1'b1, 16'h12AF, 4'h0);
    tick("load_12af");
    applyStimulus(1'b1, 1'b0, 16'h0, 4'h0);
    repeat (60) tick("show_12af");

    $display("[TB] load 0001 in the frame_done cycle");
    for (int i = 0; i < FRAME + 2 && !m_fd; i++) tick("seek_fd");
    checkOutput("seek_fd", {15'b0, frame_done}, 16'd1);
    applyStimulus(1'b1, 1'b1, 16'h0001, 4'h0);
    tick("load_at_fd");
    applyStimulus(1'b1, 1'b1, 16'h5555, 4'h0);
    repeat (2 * FRAME + 4) tick("held_valid");
    applyStimulus(1'b1, 1'b0, 16'h0, 4'h0);
    repeat (60) tick("show_0001");

    $display("[TB] en low with load BEEF, then dp on digit 2");
    applyStimulus(1'b0, 1'b1, 16'hBEEF, 4'h0);
    tick("load_beef_dis");
    applyStimulus(1'b0, 1'b0, 16'h0, 4'h0);
    repeat (4) tick("disabled");
    applyStimulus(1'b1, 1'b0, 16'h0, 4'b0100);
    repeat (50) tick("show_beef");

    $display("[TB] leading-zero values 0030 and 0000");
    applyStimulus(1'b1, 1'b1, 16'h0030, 4'h0);
    tick("load_0030");
    applyStimulus(1'b1, 1'b0, 16'h0, 4'h0);
    repeat (60) tick("show_0030");
    applyStimulus(1'b1, 1'b1, 16'h0000, 4'h0);
    tick("load_0000");
    applyStimulus(1'b1, 1'b0, 16'h0, 4'h0);
    repeat (60) tick("show_0000");

    $display("[TB] randomized traffic");
    for (int i = 0; i < 1500; i++) begin
      logic e;
      e = en;
      if ($urandom_range(0, 39) == 0) e = ~e;
      applyStimulus(e, ($urandom_range(0, 3) == 0), 16'($urandom), 4'($urandom));
      tick("random");
      if ($urandom_range(0, 499) == 0) pulseReset("rst_random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
